// File: rtl/umi_requester.sv
// Single-outstanding UMI host requester: local read/write/posted commands in, UMI requests out, responses tracked.
// Optional response timeout enabled by defining UMI_REQUESTER_TIMEOUT_EN.
module umi_requester #(
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int DW      = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [AW-1:0] host_srcaddr,
  input  logic          loc_valid,
  output logic          loc_ready,
  input  logic          loc_write,
  input  logic          loc_posted,
  input  logic [AW-1:0] loc_addr,
  input  logic [2:0]    loc_size,
  input  logic [7:0]    loc_len,
  input  logic [DW-1:0] loc_wrdata,
  output logic          loc_done,
  output logic [1:0]    loc_err,
  output logic [DW-1:0] loc_rddata,
  output logic          loc_stray,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // opcode[4:0] size[7:5] len[15:8] eom[22] eof[23]; everything else zero
  function automatic logic [CW-1:0] umi_pack(input logic [4:0] opcode,
                                             input logic [2:0] size,
                                             input logic [7:0] len);
    logic [CW-1:0] c;
    c       = '0;
    c[4:0]  = opcode;
    c[7:5]  = size;
    c[15:8] = len;
    c[22]   = 1'b1;
    c[23]   = 1'b1;
    return c;
  endfunction

  state_t     state;
  logic [1:0] rsync;
  logic       ready_gated;
  logic       is_write, is_posted;
  logic       resp_hs, accept;
  logic [4:0] resp_opcode, exp_opcode;
  logic [1:0] resp_err, resp_status;

  // reset release synchroniser; holds off handshakes until reset is cleanly gone
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) rsync <= 2'b00;
    else         rsync <= {rsync[0], 1'b1};

  assign ready_gated      = rsync[1];
  assign loc_ready        = ready_gated && (state == IDLE);
  assign uhost_resp_ready = ready_gated && (state != REQ);
  assign accept           = loc_valid && loc_ready;
  assign resp_hs          = uhost_resp_valid && uhost_resp_ready;

  assign resp_opcode = uhost_resp_cmd[4:0];
  assign resp_err    = uhost_resp_cmd[26:25];
  assign exp_opcode  = is_write ? UMI_RESP_WRITE : UMI_RESP_READ;
  assign resp_status = (resp_opcode != exp_opcode) ? 2'b01 :
                       (resp_err != 2'b00)         ? 2'b11 : 2'b00;

  // routing fields of the response are not needed with a single outstanding request
  logic resp_unused;
  assign resp_unused = ^{uhost_resp_dstaddr, uhost_resp_srcaddr,
                         uhost_resp_cmd[CW-1:27], uhost_resp_cmd[24:5]};

`ifdef UMI_REQUESTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_nxt;
  logic          to_hit;
  assign to_cnt_nxt = to_cnt + 1'b1;
  assign to_hit     = (to_cnt_nxt == TW'(TIMEOUT));
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state             <= IDLE;
      is_write          <= 1'b0;
      is_posted         <= 1'b0;
      uhost_req_valid   <= 1'b0;
      uhost_req_cmd     <= '0;
      uhost_req_dstaddr <= '0;
      uhost_req_srcaddr <= '0;
      uhost_req_data    <= '0;
      loc_done          <= 1'b0;
      loc_err           <= 2'b00;
      loc_rddata        <= '0;
      loc_stray         <= 1'b0;
`ifdef UMI_REQUESTER_TIMEOUT_EN
      to_cnt            <= '0;
`endif
    end else begin
      loc_done  <= 1'b0;
      loc_stray <= 1'b0;
      case (state)
        IDLE: begin
          if (resp_hs) loc_stray <= 1'b1;
          if (accept) begin
            is_write          <= loc_write;
            is_posted         <= loc_write && loc_posted;
            uhost_req_valid   <= 1'b1;
            uhost_req_cmd     <= umi_pack(!loc_write ? UMI_REQ_READ :
                                          loc_posted ? UMI_REQ_POSTED : UMI_REQ_WRITE,
                                          loc_size, loc_len);
            uhost_req_dstaddr <= loc_addr;
            uhost_req_srcaddr <= host_srcaddr;
            uhost_req_data    <= loc_write ? loc_wrdata : '0;
            state             <= REQ;
          end
        end
        REQ: begin
          if (uhost_req_ready) begin
            uhost_req_valid <= 1'b0;
            if (is_posted) begin
              loc_done   <= 1'b1;
              loc_err    <= 2'b00;
              loc_rddata <= '0;
              state      <= IDLE;
            end else begin
              state <= WAIT;
`ifdef UMI_REQUESTER_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (resp_hs) begin
            loc_done   <= 1'b1;
            loc_err    <= resp_status;
            loc_rddata <= (!is_write && resp_status == 2'b00) ? uhost_resp_data : '0;
            state      <= IDLE;
          end
`ifdef UMI_REQUESTER_TIMEOUT_EN
          else if (to_hit) begin
            loc_done   <= 1'b1;
            loc_err    <= 2'b10;
            loc_rddata <= '0;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt_nxt;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umi_requester.sv
// Scoreboard bench for umi_requester: completions/strays are predicted at stimulus time and checked on output.
module tb_umi_requester;
  localparam int CW = 32, AW = 64, DW = 256;
`ifdef UMI_REQUESTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          clk = 1'b0, nreset = 1'b0;
  logic [AW-1:0] host_srcaddr;
  logic          loc_valid, loc_ready, loc_write, loc_posted;
  logic [AW-1:0] loc_addr;
  logic [2:0]    loc_size;
  logic [7:0]    loc_len;
  logic [DW-1:0] loc_wrdata, loc_rddata;
  logic          loc_done, loc_stray;
  logic [1:0]    loc_err;
  logic          uhost_req_valid, uhost_req_ready;
  logic [CW-1:0] uhost_req_cmd;
  logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
  logic [DW-1:0] uhost_req_data;
  logic          uhost_resp_valid, uhost_resp_ready;
  logic [CW-1:0] uhost_resp_cmd;
  logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
  logic [DW-1:0] uhost_resp_data;

  always #5 clk = ~clk;

  umi_requester #(.CW(CW), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .nreset(nreset), .host_srcaddr(host_srcaddr),
    .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_write(loc_write),
    .loc_posted(loc_posted), .loc_addr(loc_addr), .loc_size(loc_size),
    .loc_len(loc_len), .loc_wrdata(loc_wrdata), .loc_done(loc_done),
    .loc_err(loc_err), .loc_rddata(loc_rddata), .loc_stray(loc_stray),
    .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
    .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
    .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
    .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
    .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
  );

  typedef struct {
    logic          stray;
    logic [1:0]    err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic stray, input logic [1:0] err, input logic [DW-1:0] data);
    exp_t e;
    e.stray = stray; e.err = err; e.data = data;
    return e;
  endfunction

  // completion / stray monitor
  exp_t e_mon;
  always @(negedge clk) begin
    if (loc_done || loc_stray) begin
      chk("done_stray_excl", DW'(loc_done & loc_stray), '0);
      chk("sb_pending", DW'(sb.size() > 0), DW'(1));
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        chk("sb_kind", DW'(loc_stray), DW'(e_mon.stray));
        if (!e_mon.stray) begin
          chk("sb_err", DW'(loc_err), DW'(e_mon.err));
          chk("sb_rddata", loc_rddata, e_mon.data);
        end
      end
    end
  end

  task automatic send(input logic w, input logic p, input logic [AW-1:0] a,
                      input logic [2:0] sz, input logic [7:0] ln, input logic [DW-1:0] wd);
    int n;
    loc_write = w; loc_posted = p; loc_addr = a; loc_size = sz; loc_len = ln;
    loc_wrdata = wd; loc_valid = 1'b1;
    n = 0;
    while (!loc_ready && n < 50) begin tick; n++; end
    if (n >= 50) chk("accept_timeout", DW'(loc_ready), DW'(1));
    tick;
    loc_valid = 1'b0;
    chk("req_latency", DW'(uhost_req_valid), DW'(1));
  endtask

  task automatic req_hs;
    chk("req_valid_hs", DW'(uhost_req_valid), DW'(1));
    uhost_req_ready = 1'b1;
    tick;
    uhost_req_ready = 1'b0;
    chk("req_drop", DW'(uhost_req_valid), DW'(0));
  endtask

  task automatic respond(input logic [4:0] op, input logic [1:0] ferr, input logic [DW-1:0] d,
                         input logic stray, input logic [1:0] xerr, input logic [DW-1:0] xd);
    sb.push_back(mk(stray, xerr, xd));
    uhost_resp_cmd = {5'd0, ferr, 20'd0, op};
    uhost_resp_data = d;
    uhost_resp_valid = 1'b1;
    chk("resp_ready", DW'(uhost_resp_ready), DW'(1));
    tick;
    uhost_resp_valid = 1'b0;
    if (stray) begin
      chk("stray_pulse", DW'(loc_stray), DW'(1));
      chk("stray_no_done", DW'(loc_done), DW'(0));
    end else begin
      chk("done_latency", DW'(loc_done), DW'(1));
      chk("ready_with_done", DW'(loc_ready), DW'(1));
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_loc_ready"}, DW'(loc_ready), '0);
    chk({tag, "_resp_ready"}, DW'(uhost_resp_ready), '0);
    chk({tag, "_req_valid"}, DW'(uhost_req_valid), '0);
    chk({tag, "_req_cmd"}, DW'(uhost_req_cmd), '0);
    chk({tag, "_req_addr"}, DW'({uhost_req_dstaddr, uhost_req_srcaddr}), '0);
    chk({tag, "_req_data"}, uhost_req_data, '0);
    chk({tag, "_done_err_stray"}, DW'({loc_done, loc_err, loc_stray}), '0);
    chk({tag, "_rddata"}, loc_rddata, '0);
  endtask

  initial begin
    int n;
    host_srcaddr = 64'h20; loc_valid = 0; loc_write = 0; loc_posted = 0;
    loc_addr = '0; loc_size = '0; loc_len = '0; loc_wrdata = '0;
    uhost_req_ready = 0; uhost_resp_valid = 0; uhost_resp_cmd = '0;
    uhost_resp_dstaddr = '0; uhost_resp_srcaddr = '0; uhost_resp_data = '0;

    repeat (3) tick;
    reset_outputs_zero("rst");
    nreset = 1'b1;
    tick;
    chk("gate_sync1", DW'(loc_ready), DW'(0));
    tick;
    chk("gate_sync2", DW'(loc_ready), DW'(1));

    // read 0x1000, response after 5 cycles
    send(0, 0, 64'h1000, 3'd3, 8'd0, '0);
    chk("rd_cmd", DW'(uhost_req_cmd), DW'(32'h00C0_0061));
    chk("rd_dst", DW'(uhost_req_dstaddr), DW'(64'h1000));
    chk("rd_src", DW'(uhost_req_srcaddr), DW'(64'h20));
    chk("rd_data", uhost_req_data, '0);
    chk("req_no_resp_ready", DW'(uhost_resp_ready), DW'(0));
    req_hs;
    repeat (4) tick;
    respond(5'h02, 2'b00, DW'(32'hDEADBEEF), 0, 2'b00, DW'(32'hDEADBEEF));

    // posted write with req_ready held low for 3 cycles
    send(1, 1, 64'h2000, 3'd2, 8'd3, DW'(64'hCAFE_F00D_1234_5678));
    for (int i = 0; i < 4; i++) begin
      chk("pw_valid", DW'(uhost_req_valid), DW'(1));
      chk("pw_cmd", DW'(uhost_req_cmd), DW'(32'h00C0_0345));
      chk("pw_data", uhost_req_data, DW'(64'hCAFE_F00D_1234_5678));
      chk("pw_no_resp_ready", DW'(uhost_resp_ready), DW'(0));
      if (i == 3) begin
        sb.push_back(mk(0, 2'b00, '0));
        uhost_req_ready = 1'b1;
      end
      tick;
    end
    uhost_req_ready = 1'b0;
    chk("pw_done", DW'(loc_done), DW'(1));

    // write answered with a read response: opcode mismatch
    send(1, 0, 64'h3000, 3'd2, 8'd0, DW'(32'h1111));
    chk("wr_cmd", DW'(uhost_req_cmd), DW'(32'h00C0_0043));
    req_hs;
    tick;
    respond(5'h02, 2'b00, DW'(32'h9999), 0, 2'b01, '0);

    // write answered with err field 2
    send(1, 0, 64'h3008, 3'd2, 8'd0, DW'(32'h2222));
    req_hs;
    respond(5'h04, 2'b10, '0, 0, 2'b11, '0);

    // read answered with err field 1: data must be suppressed
    send(0, 0, 64'h4000, 3'd3, 8'd1, '0);
    req_hs;
    respond(5'h02, 2'b01, DW'(32'h7777), 0, 2'b11, '0);

    // opcode mismatch outranks err field
    send(0, 0, 64'h4008, 3'd3, 8'd0, '0);
    req_hs;
    respond(5'h04, 2'b11, DW'(32'h5555), 0, 2'b01, '0);

    // response with nothing outstanding
    tick;
    respond(5'h02, 2'b00, DW'(32'hBAD), 1, 2'b00, '0);
    tick;
    chk("stray_once", DW'(loc_stray), DW'(0));

`ifdef UMI_REQUESTER_TIMEOUT_EN
    send(0, 0, 64'h5000, 3'd3, 8'd0, '0);
    sb.push_back(mk(0, 2'b10, '0));
    req_hs;
    n = 0;
    while (!loc_done && n < 100) begin tick; n++; end
    chk("timeout_cycles", DW'(n), DW'(16));
    tick;
    respond(5'h02, 2'b00, DW'(32'h6666), 1, 2'b00, '0);
`endif

    // reset during WAIT drops the transaction
    send(0, 0, 64'h6000, 3'd3, 8'd0, '0);
    req_hs;
    tick;
    nreset = 1'b0;
    #1;
    reset_outputs_zero("midrst");
    tick;
    nreset = 1'b1;
    tick;
    chk("midrst_gated", DW'(loc_ready), DW'(0));
    tick;
    chk("midrst_ready", DW'(loc_ready), DW'(1));
    respond(5'h02, 2'b00, DW'(32'h4242), 1, 2'b00, '0);
    send(0, 0, 64'h7000, 3'd3, 8'd0, '0);
    req_hs;
    tick;
    respond(5'h02, 2'b00, DW'(64'h0123_4567_89AB_CDEF), 0, 2'b00, DW'(64'h0123_4567_89AB_CDEF));

    repeat (3) tick;
    chk("sb_drained", DW'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
